contador_multicanal: RTL

CONTADOR_MULTICANAL -- requirements
Module: contador_multicanal

---
 rtl/contador_multicanal.sv | 119 +++++++++++
 1 files changed

// File: rtl/contador_multicanal.sv
// contador_multicanal: NCH independent push counters with sticky overflow and a one-cycle read port.
// Build option: define CONTADOR_SAT_EN to saturate counters at 2**CW-1 instead of wrapping to 0.
module contador_multicanal #(
  parameter int NCH = 8,
  parameter int CW  = 5,
  parameter int IW  = 3
) (
  input  logic           clk,
  input  logic           reset_L,
  input  logic [NCH-1:0] push,
  input  logic           req,
  input  logic [IW-1:0]  idx,
  input  logic           rd_clr,
  output logic [CW-1:0]  data,
  output logic           valid,
  output logic [NCH-1:0] ovf,
  output logic           busy
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    ACTIVE
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt     [NCH];
  logic [CW-1:0]  cnt_nxt [NCH];
  logic [NCH-1:0] ovf_nxt;
  logic [NCH-1:0] sel;
  logic [CW-1:0]  rd_val;
  logic           idx_ok;
  logic           rd_go;
  logic           counting;

  // One-hot decode of idx; an out-of-range idx selects nothing and reads back 0.
  always_comb begin
    sel    = '0;
    rd_val = '0;
    for (int i = 0; i < NCH; i++) begin
      if (idx == IW'(i)) begin
        sel[i] = 1'b1;
        rd_val = cnt[i];
      end
    end
  end

  assign idx_ok   = |sel;
  assign counting = (state != INIT);
  assign rd_go    = counting && req;

  // Clear-on-read overrides the increment, but a same-edge push still lands as the first new event.
  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    for (int i = 0; i < NCH; i++) begin
      if (counting && push[i]) begin
        if (cnt[i] == CNT_MAX) begin
          ovf_nxt[i] = 1'b1;
`ifdef CONTADOR_SAT_EN
          cnt_nxt[i] = CNT_MAX;
`else
          cnt_nxt[i] = '0;
`endif
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
      if (rd_go && rd_clr && sel[i]) begin
        cnt_nxt[i] = {{(CW-1){1'b0}}, push[i]};
        ovf_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state <= INIT;
      cnt   <= '{default: '0};
      ovf   <= '0;
      data  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
      case (state)
        INIT: begin
          state <= IDLE;
          data  <= '0;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
        IDLE, ACTIVE: begin
          if (req) begin
            state <= ACTIVE;
            data  <= rd_val;
            valid <= idx_ok;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            data  <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= INIT;
          data  <= '0;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
